// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : serial_sub_pkg

// File: rtl/half_subtractor.sv
// Single-bit half subtractor: diff = a ^ b, borrow = ~a & b.
// Two of these plus an OR of the borrows make one full-subtractor bit.
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic diff,
    output logic borrow
);

    assign diff   = a ^ b;
    assign borrow = ~a & b;

endmodule : half_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial, LSB-first unsigned subtractor computing a - b over WIDTH
// cycles behind a start/done handshake.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; operands load on the accepting edge
//   RUN   | one bit of sa/sb/br processed per edge, cnt = bit index
//   DONE  | one-cycle done pulse, diff/borrow_out valid, then back to IDLE
//
// diff and borrow_out live in their own registers, loaded on the final RUN
// edge, so they stay stable while the result shift register is reused by a
// later operation.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               br_q, br_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               hs1_diff, hs1_borrow;
    logic               bit_diff, hs2_borrow;
    logic               bit_borrow;
    logic [WIDTH-1:0]   r_shifted;

    // Stage 1: operand bits.  Stage 2: stage-1 difference against the
    // borrow carried in from the previous bit.
    half_subtractor u_hs_stage1 (
        .a      (sa_q[0]),
        .b      (sb_q[0]),
        .diff   (hs1_diff),
        .borrow (hs1_borrow)
    );

    half_subtractor u_hs_stage2 (
        .a      (hs1_diff),
        .b      (br_q),
        .diff   (bit_diff),
        .borrow (hs2_borrow)
    );

    assign bit_borrow = hs1_borrow | hs2_borrow;
    assign r_shifted  = {bit_diff, r_q[WIDTH-1:1]};

    // Next-state and datapath update; every target defaults to holding.
    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                end
            end

            RUN: begin
                sa_d = sa_q >> 1;
                sb_d = sb_q >> 1;
                r_d  = r_shifted;
                br_d = bit_borrow;
                if (cnt_q == CNT_LAST) begin
                    // Final bit: publish the result, keep cnt at WIDTH-1.
                    state_d  = DONE;
                    diff_d   = r_shifted;
                    borrow_d = bit_borrow;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // busy/done are decoded from the next state so they can be registered
    // and still line up with the state they describe.
    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers; async active-low reset clears all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=2, with
// an arithmetic reference model (a - b mod 2^W, a < b).
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8, bo8;
    logic [7:0] diff8;

    logic       start2;
    logic [1:0] a2, b2;
    logic       busy2, done2, bo2;
    logic [1:0] diff2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start8),
        .a          (a8),
        .b          (b8),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (bo8)
    );

    serial_subtractor #(.WIDTH(2)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start2),
        .a          (a2),
        .b          (b2),
        .busy       (busy2),
        .done       (done2),
        .diff       (diff2),
        .borrow_out (bo2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] get_diff(input bit w2);
        return w2 ? {6'b0, diff2} : diff8;
    endfunction

    function automatic logic get_bo(input bit w2);
        return w2 ? bo2 : bo8;
    endfunction

    function automatic logic get_done(input bit w2);
        return w2 ? done2 : done8;
    endfunction

    function automatic logic get_busy(input bit w2);
        return w2 ? busy2 : busy8;
    endfunction

    // One operation on the selected DUT; checks latency, result, pulse
    // width, busy release and result hold for 'hold' idle cycles.
    task automatic run_op(input bit w2, input logic [7:0] a, input logic [7:0] b, input int hold);
        int         w;
        int         cyc;
        logic [7:0] mask;
        logic [7:0] am, bm;
        logic [7:0] exp_d;
        logic       exp_b;
        w     = w2 ? 2 : 8;
        mask  = w2 ? 8'h03 : 8'hFF;
        am    = a & mask;
        bm    = b & mask;
        exp_b = (am < bm);
        exp_d = (am - bm) & mask;

        @(negedge clk);
        if (w2) begin start2 = 1'b1; a2 = am[1:0]; b2 = bm[1:0]; end
        else    begin start8 = 1'b1; a8 = am;      b8 = bm;      end
        @(negedge clk);
        start2 = 1'b0; start8 = 1'b0;
        a8 = 8'($urandom()); b8 = 8'($urandom());
        a2 = 2'($urandom()); b2 = 2'($urandom());
        check("busy_after_start", 32'(get_busy(w2)), 32'd1);

        cyc = 0;
        while (!get_done(w2) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'(w));
        check("diff", 32'(get_diff(w2)), 32'(exp_d));
        check("borrow_out", 32'(get_bo(w2)), 32'(exp_b));

        @(negedge clk);
        check("done_pulse_width", 32'(get_done(w2)), 32'd0);
        check("busy_released", 32'(get_busy(w2)), 32'd0);

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_diff", 32'(get_diff(w2)), 32'(exp_d));
            check("hold_borrow", 32'(get_bo(w2)), 32'(exp_b));
            check("hold_done", 32'(get_done(w2)), 32'd0);
        end
    endtask

    logic [7:0] opa [0:63];
    logic [7:0] opb [0:63];

    initial begin
        logic [7:0] ea, eb;
        rst_n  = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start2 = 1'b0; a2 = '0; b2 = '0;
        #1;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_diff", 32'(diff8), 32'd0);
        check("rst_borrow", 32'(bo8), 32'd0);
        check("rst_busy2", 32'(busy2), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        run_op(1'b0, 8'h5A, 8'h23, 3);
        run_op(1'b0, 8'h23, 8'h5A, 3);
        run_op(1'b0, 8'h00, 8'h01, 3);
        run_op(1'b0, 8'hFF, 8'hFF, 20);
        run_op(1'b0, 8'h00, 8'h01, 0);

        // Reset four cycles into RUN discards the operation.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'h23;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_busy", 32'(busy8), 32'd0);
        check("midrun_rst_done", 32'(done8), 32'd0);
        check("midrun_rst_diff", 32'(diff8), 32'd0);
        check("midrun_rst_borrow", 32'(bo8), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("no_done_after_rst", 32'(done8), 32'd0);
        end
        run_op(1'b0, 8'hA5, 8'h3C, 2);

        // Start held high, operands changing every cycle: accepts at
        // cycles 0,10,20,...; each done is visible 9 negedges later.
        @(negedge clk);
        start8 = 1'b1;
        opa[0] = 8'($urandom()); opb[0] = 8'($urandom());
        a8 = opa[0]; b8 = opb[0];
        for (int c = 1; c < 60; c++) begin
            @(negedge clk);
            check("b2b_done", 32'(done8), 32'((c % 10) == 9));
            check("b2b_busy", 32'(busy8), 32'((c % 10) != 0));
            if ((c % 10) == 9) begin
                ea = opa[c-9]; eb = opb[c-9];
                check("b2b_diff", 32'(diff8), 32'(8'(ea - eb)));
                check("b2b_borrow", 32'(bo8), 32'(ea < eb));
            end
            if (c == 59) begin
                start8 = 1'b0;
            end else begin
                opa[c] = 8'($urandom()); opb[c] = 8'($urandom());
                a8 = opa[c]; b8 = opb[c];
            end
        end
        repeat (2) @(negedge clk);

        // Random sweeps.
        for (int i = 0; i < 1000; i++) run_op(1'b0, 8'($urandom()), 8'($urandom()), 0);
        run_op(1'b1, 8'h00, 8'h01, 2);
        run_op(1'b1, 8'h03, 8'h03, 2);
        for (int i = 0; i < 1000; i++) run_op(1'b1, 8'($urandom()), 8'($urandom()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule : tb_serial_subtractor
